// File: rtl/byte_fifo_arbiter_pkg.sv
// Shared constants and state encoding for the packet-aware byte FIFO arbiter.
package byte_fifo_arbiter_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int BYTE_W     = 8;
    localparam int MAX_NREQ   = 8;
    localparam int ADDR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int OWN_W      = $clog2(MAX_NREQ);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/byte_fifo_arbiter_srl_fifo.sv
// Shift-register FIFO: newest byte enters at slot 0, the oldest sits at slot count-1.
module srl_fifo
    import byte_fifo_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [BYTE_W-1:0] din,
    input  logic              rd,
    output logic [BYTE_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    logic [BYTE_W-1:0] mem [FIFO_DEPTH];
    logic [CNT_W-1:0]  count;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_idx;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign wr_en  = wr & ~full;
    assign rd_en  = rd & ~empty;
    assign rd_idx = ADDR_W'(count - CNT_W'(1));
    assign dout   = mem[rd_idx];

    // Storage carries no reset so it maps onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[0] <= din;
            for (int i = 1; i < FIFO_DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_en && !rd_en) begin
            count <= count + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/byte_fifo_arbiter.sv
// Round-robin, packet-locking write arbiter in front of a shared byte FIFO,
// with a watchdog that releases an owner stalled mid-packet.
module byte_fifo_arbiter
    import byte_fifo_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        last,
    input  logic [BYTE_W*NREQ-1:0] din,
    output logic [NREQ-1:0]        gnt,
    output logic [BYTE_W-1:0]      m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [OWN_W-1:0]       owner,
    output logic                   locked,
    output logic                   lock_err
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [7:0]        wdog_q, wdog_d;
    logic              lock_err_q, lock_err_d;

    logic [IDX_W-1:0]  pick;
    logic              pick_valid;
    int                scan_idx;
    logic [IDX_W-1:0]  win_idx;
    logic              win_req;
    logic              win_last;
    logic [BYTE_W-1:0] win_byte;
    logic              timeout;
    logic              accept;
    logic              full;
    logic              empty;

    // Rotate-priority scan starting just after the last producer served.
    always_comb begin
        pick       = rr_q;
        pick_valid = 1'b0;
        scan_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(rr_q) + k) % NREQ;
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick       = IDX_W'(scan_idx);
            end
        end
    end

    always_comb begin
        win_idx  = (state_q == LOCKED) ? owner_q : pick;
        win_req  = 1'b0;
        win_last = 1'b0;
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                win_req  = req[i];
                win_last = last[i];
                win_byte = din[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // The timeout cycle itself grants nobody.
    assign timeout = (state_q == LOCKED) && (wdog_q == 8'(TIMEOUT));
    assign accept  = (state_q == LOCKED) ? (win_req & ~timeout & ~full)
                                         : (pick_valid & ~full);
    assign gnt     = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        wdog_d     = '0;
        lock_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && win_last) begin
                    rr_d = pick;
                end else if (accept) begin
                    state_d = LOCKED;
                    owner_d = pick;
                end
            end
            LOCKED: begin
                if (timeout) begin
                    state_d    = IDLE;
                    rr_d       = owner_q;
                    lock_err_d = 1'b1;
                end else if (accept) begin
                    if (win_last) begin
                        state_d = IDLE;
                        rr_d    = owner_q;
                    end
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= IDX_W'(NREQ - 1);
            owner_q    <= '0;
            wdog_q     <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            wdog_q     <= wdog_d;
            lock_err_q <= lock_err_d;
        end
    end

    srl_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (|gnt),
        .din   (win_byte),
        .rd    (m_valid & m_ready),
        .dout  (m_data),
        .empty (empty),
        .full  (full)
    );

    assign m_valid  = ~empty;
    assign locked   = (state_q == LOCKED);
    assign owner    = OWN_W'(owner_q);
    assign lock_err = lock_err_q;

endmodule

// File: doc/byte_fifo_arbiter.md
# byte_fifo_arbiter

Round-robin, packet-aware write arbiter that shares one 16-deep, 8-bit SRL FIFO between NREQ byte producers and drains it to a single consumer over a valid/ready handshake. It sits between the protocol front-ends (UART/command generators) and the common output serializer. It guarantees that multi-byte packets from one producer are never interleaved with bytes from another. A watchdog breaks a lock held by a producer that stalls mid-packet.

## Interface
- NREQ, 4: number of producers (2..8)
- TIMEOUT, 255: idle cycles a locked owner may hold the FIFO without writing (1..255)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  NREQ  per-producer "byte available"
- last  in  NREQ  per-producer "this byte ends the packet"
- din  in  8*NREQ  producer bytes; producer i on bits [8i+7:8i]
- gnt  out  NREQ  one-hot accept strobe; byte of producer i written this cycle
- m_data  out  8  oldest FIFO byte
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer takes m_data this cycle
- owner  out  3  index of locked producer; valid while locked=1
- locked  out  1  packet in progress
- lock_err  out  1  one-cycle pulse when the watchdog releases a lock

## Operation
- FSM states: IDLE, LOCKED.
- IDLE:
  - Combinationally select the first requester with req=1, scanning from rr_ptr+1 upward modulo NREQ.
  - If FIFO not full, assert gnt for that requester and write its byte.
  - Accepted byte with last=1: stay IDLE; rr_ptr <= winner.
  - Accepted byte with last=0: go to LOCKED; owner <= winner.
  - No gnt when FIFO is full, even if req is asserted.
- LOCKED:
  - Only the owner is eligible. gnt[owner] = req[owner] & ~full.
  - Accepted byte with last=1: go to IDLE; rr_ptr <= owner.
  - Watchdog counter clears on each accepted byte and increments on every other cycle.
  - When the counter reaches TIMEOUT: go to IDLE, rr_ptr <= owner, pulse lock_err. The same cycle accepts no byte from anyone.
- Drain side:
  - m_valid = ~empty.
  - FIFO rd = m_valid & m_ready.
  - A simultaneous write and read is permitted, and occupancy is unchanged.
- gnt is combinational from registered state, req and full. Producers treat gnt[i] as a pop of their own source.
- din is sampled only for the granted producer. last is ignored without gnt.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=NREQ-1 (producer 0 has first priority), owner=0, watchdog=0.
  - Outputs: locked=0, lock_err=0, gnt=0, m_valid=0.
  - FIFO occupancy=0.
  - rst mid-packet drops FIFO contents and any lock immediately.
- Write latency: a byte with gnt in cycle n appears on m_data/m_valid in cycle n+1 if the FIFO was empty.
- m_data is stable while m_valid=1 and m_ready=0.
- Full boundary: with 16 bytes stored, gnt=0. A read in the same cycle does not enable a write; the write waits one cycle.
- Empty boundary: m_valid=0 and m_ready is ignored. The FIFO never underflows.
- locked and owner update the cycle after the accepting gnt.
- lock_err is high for exactly 1 cycle, the cycle after the watchdog hits TIMEOUT.

## Structure
- Shared package holds:
  - FIFO_DEPTH=16 and the 8-bit byte width.
  - State encodings IDLE=1'b0, LOCKED=1'b1.
  - The maximum NREQ constant.
- One sub-module, srl_fifo, instantiated unchanged for storage: wr=|gnt, rd from the drain handshake, status via empty/full.
- Round-robin pick stays inline as a rotate-priority-encode loop. Watchdog is an inline 8-bit counter.

## Test plan
- Reset, then req=4'b0001, last=1, din0=8'hA5 -> gnt=0001 in the same cycle; next cycle m_valid=1, m_data=A5; locked stays 0.
- req=4'b1111, all last=1, m_ready=0 -> gnt sequence 0001,0010,0100,1000,0001… for 16 accepts, then gnt=0 with the FIFO full.
- Producer 2 sends 3 bytes (last=0,0,1) while producers 0/1 request -> bytes 2a,2b,2c are contiguous on m_data; locked=1, owner=2 until 2c; next grant goes to producer 3 or wraps to 0.
- Producer 1 locks with last=0, then drops req for TIMEOUT=4 cycles -> lock_err pulses once; in the following cycle producer 2 is granted.
- FIFO full, m_ready=1 with all req=1 -> one byte drained, no write that cycle, write the next cycle; occupancy returns to 16.
- Assert rst mid-packet with 7 bytes stored -> m_valid=0, locked=0 next cycle; after release the first grant goes to the lowest-index requester.
